avalon_pio_gen: RTL and testbench
=================================

Name: avalon_pio_gen

Overview:
- Parametrised Avalon-MM PIO slave; successor to the single-bit chip-select output ports, e.g. the touch controller nCS.
- Provides a WIDTH-bit port with per-bit direction and atomic set/clear of output bits.
- Samples inputs through a synchroniser and captures edges with a maskable interrupt.
- Sits between the Nios II data master and board pins: SPI chip selects, TFT control lines, touch PENIRQ and similar.

Parameters:
- WIDTH, 8, port width in bits (1..32).
- RESET_VALUE, 32'h0000_00FF, reset value of the output data register; low WIDTH bits used. Default drives all chip selects inactive-high.
- DIR_RESET, 32'hFFFF_FFFF, reset value of the direction register; 1 = output. Low WIDTH bits used.
- EDGE_TYPE, 0, edge-capture mode: 0 rising, 1 falling, 2 any edge.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  register word address.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  active-low write strobe; valid only with chipselect.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational from address, zero wait states.
- in_port  in  WIDTH  asynchronous pin inputs.
- out_port  out  WIDTH  output data register.
- oe  out  WIDTH  per-bit output enable; equals the direction register.
- irq  out  1  interrupt, active-high, level.

Behaviour:
Register map (word addresses):
- 0 DATA. Read: bit i = out_reg[i] if dir[i], else sync_in[i]. Write: out_reg <= writedata.
- 1 DIR. Read/write.
- 2 IRQMASK. Read/write.
- 3 EDGECAP. Read: captured edges. Write: write-1-to-clear per bit.
- 4 OUTSET. Write: out_reg <= out_reg | writedata. Read returns 0.
- 5 OUTCLR. Write: out_reg <= out_reg & ~writedata. Read returns 0.
- 6, 7 reserved. Read 0; writes ignored.

Register write and read rules:
- A write occurs on a clk edge where chipselect=1 and write_n=0. It takes effect on that edge; out_port/oe update the following cycle.
- readdata bits [31:WIDTH] are always 0. writedata bits above WIDTH are ignored.
- Reads have no side effects. readdata is defined regardless of chipselect.

Reset values:
- out_reg = RESET_VALUE[WIDTH-1:0]; dir = DIR_RESET[WIDTH-1:0].
- irqmask = 0; edgecap = 0; sync stages s1/s2/s3 = 0; prime counter = 0; irq = 0.
- Reset asserted mid-operation overrides any same-cycle write.

Input path:
- s1 <= in_port; s2 <= s1; s3 <= s2. sync_in = s2.
- Edge term: rise = s2&~s3; fall = ~s2&s3; any = s2^s3. EDGE_TYPE selects the term.

Prime counter:
- A 2-bit counter counts 0->3 after reset and saturates at 3.
- Edge capture is enabled only when the count = 3.
- This suppresses spurious edges from inputs already high at reset.

Edge capture:
- edgecap[i] <= (edgecap[i] & ~clr[i]) | (edge[i] & en & ~dir[i]).
- Output-direction bits never capture.
- Simultaneous clear and new edge on the same bit: the edge wins and the bit stays 1.

Interrupt:
- irq = |(edgecap & irqmask); combinational from registers.
- Latency: an in_port transition settled before clk edge k gives s2 at edge k+1, edgecap at edge k+2, irq high after edge k+2.
- Unmasking an already-captured bit raises irq the cycle after the IRQMASK write.

Direction change:
- Switching a bit to output does not clear its edgecap; only software clears it.

Test Plan:
1. Reset with WIDTH=8 defaults -> out_port=8'hFF, oe=8'hFF, irq=0; read of addr 0 returns 32'h0000_00FF, addr 3 returns 0.
2. Write OUTCLR 8'h01, then OUTSET 8'h10 -> out_port 8'hFE after the first write, 8'hFE|8'h10=8'hFE (bit 4 already set); then write DATA 8'h00 and OUTSET 8'h05 -> out_port 8'h05.
3. DIR=8'h0F, IRQMASK=8'h10, EDGE_TYPE=0; raise in_port[4] -> EDGECAP reads 8'h10 and irq=1 exactly 3 clk edges after the change. Write EDGECAP 8'h10 -> irq=0 next cycle.
4. Hold in_port=8'hFF through reset with DIR=0 after release -> EDGECAP stays 0, irq stays 0; subsequent fall and rise on bit 2 sets bit 2 only.
5. Write-1-clear of EDGECAP bit 3 on the same cycle a new rising edge on bit 3 is detected -> bit 3 reads 1 afterwards.
6. Write to addr 6 with 32'hFFFF_FFFF -> no register changes; reads of addr 4/5/6/7 return 0; assert reset during a DATA write -> RESET_VALUE wins.

Source files
------------

// File: rtl/avalon_pio_gen.sv
// avalon_pio_gen: Avalon-MM PIO slave with per-bit direction, atomic set/clear
// and synchronised, primed edge capture driving a maskable level interrupt.
module avalon_pio_gen #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0000_00FF,
  parameter logic [31:0] DIR_RESET   = 32'hFFFF_FFFF,
  parameter int          EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);
  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, mask_q, mask_d, cap_q, cap_d;
  logic [WIDTH-1:0] s1_q, s2_q, s3_q, edge_t, clr, wd, rd;
  logic [1:0]       prime_q, prime_d;
  logic             wr;
  logic             unused_wd;
  assign unused_wd = ^writedata;
  always_comb begin
    wr      = chipselect & ~write_n;
    wd      = writedata[WIDTH-1:0];
    out_d   = !wr              ? out_q :
              address == 3'd0  ? wd :
              address == 3'd4  ? out_q | wd :
              address == 3'd5  ? out_q & ~wd : out_q;
    dir_d   = (wr && address == 3'd1) ? wd : dir_q;
    mask_d  = (wr && address == 3'd2) ? wd : mask_q;
    clr     = (wr && address == 3'd3) ? wd : '0;
    edge_t  = EDGE_TYPE == 0 ? s2_q & ~s3_q :
              EDGE_TYPE == 1 ? ~s2_q & s3_q : s2_q ^ s3_q;
    prime_d = &prime_q ? prime_q : prime_q + 2'd1;
    // a new edge beats a same-cycle software clear
    cap_d   = (cap_q & ~clr) | (edge_t & ~dir_q & {WIDTH{&prime_q}});
    rd      = address == 3'd0 ? (out_q & dir_q) | (s2_q & ~dir_q) :
              address == 3'd1 ? dir_q :
              address == 3'd2 ? mask_q :
              address == 3'd3 ? cap_q : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= RESET_VALUE[WIDTH-1:0];
      dir_q   <= DIR_RESET[WIDTH-1:0];
      mask_q  <= '0;
      cap_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      prime_q <= '0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      s1_q    <= in_port;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      prime_q <= prime_d;
    end
  end
  assign readdata = 32'(rd);
  assign out_port = out_q;
  assign oe       = dir_q;
  assign irq      = |(cap_q & mask_q);
endmodule

// File: tb/tb_avalon_pio_gen.sv
// tb_avalon_pio_gen: directed vectors with a queued-expectation monitor
module tb_avalon_pio_gen;
  localparam int W = 8;
  logic          clk = 0;
  logic          reset = 1;
  logic [2:0]    address = '0;
  logic          chipselect = 0;
  logic          write_n = 1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port = '0;
  logic [W-1:0]  out_port, oe;
  logic          irq;
  logic          chk = 0;
  int            total = 0;
  int            bad = 0;
  typedef struct {
    logic [1:0]  sel;
    logic [31:0] exp;
    string       name;
  } item_t;
  item_t         q[$];
  item_t         it;
  logic [31:0]   act;

  avalon_pio_gen #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk) begin
      while (q.size() > 0) begin
        it = q.pop_front();
        act = it.sel == 2'd0 ? readdata :
              it.sel == 2'd1 ? 32'(out_port) :
              it.sel == 2'd2 ? 32'(oe) : 32'(irq);
        total++;
        if (act !== it.exp) begin
          bad++;
          $display("FAIL %s: got %h want %h", it.name, act, it.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    tick();
    chipselect = 0; write_n = 1;
  endtask

  task automatic exp(input logic [1:0] s, input logic [31:0] e, input string n);
    q.push_back('{s, e, n});
  endtask

  task automatic sample();
    chk = 1;
    @(negedge clk);
    #1 chk = 0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    address = a;
    exp(2'd0, e, n);
    sample();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    ticks(2);
    exp(2'd1, 32'hFF, "rst_out_port");
    exp(2'd2, 32'hFF, "rst_oe");
    exp(2'd3, 32'h0, "rst_irq");
    sample();
    rd(3'd0, 32'h0000_00FF, "rst_rd_data");
    rd(3'd3, 32'h0, "rst_rd_edgecap");
    reset = 0;
    tick();
    wr(3'd5, 32'h01);
    exp(2'd1, 32'hFE, "outclr");
    sample();
    wr(3'd4, 32'h10);
    exp(2'd1, 32'hFE, "outset_noop");
    sample();
    wr(3'd0, 32'hABCD_EF00);
    exp(2'd1, 32'h00, "data_wr_upper_ignored");
    sample();
    rd(3'd0, 32'h0, "rd_data_zero");
    wr(3'd4, 32'h05);
    exp(2'd1, 32'h05, "outset");
    sample();
    wr(3'd1, 32'h0F);
    exp(2'd2, 32'h0F, "oe_dir");
    sample();
    wr(3'd2, 32'h10);
    rd(3'd2, 32'h10, "rd_irqmask");
    in_port = 8'h10;
    ticks(2);
    exp(2'd3, 32'h0, "irq_early");
    rd(3'd3, 32'h0, "cap_early");
    tick();
    exp(2'd3, 32'h1, "irq_rise");
    rd(3'd3, 32'h10, "cap_rise");
    rd(3'd0, 32'h15, "rd_data_mixed");
    wr(3'd3, 32'h10);
    exp(2'd3, 32'h0, "irq_cleared");
    rd(3'd3, 32'h0, "cap_cleared");
    wr(3'd1, 32'h07);
    in_port = 8'h18;
    ticks(3);
    rd(3'd3, 32'h08, "cap_bit3");
    exp(2'd3, 32'h0, "irq_masked");
    sample();
    wr(3'd2, 32'h18);
    exp(2'd3, 32'h1, "irq_unmask");
    sample();
    wr(3'd1, 32'h0F);
    rd(3'd3, 32'h08, "cap_kept_on_dir_out");
    wr(3'd1, 32'h07);
    wr(3'd3, 32'h08);
    rd(3'd3, 32'h0, "cap_bit3_clr");
    in_port = 8'h10;
    ticks(3);
    rd(3'd3, 32'h0, "fall_ignored");
    in_port = 8'h18;
    ticks(2);
    wr(3'd3, 32'h08);
    rd(3'd3, 32'h08, "clr_vs_edge");
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd0, 32'h1D, "rsv_data");
    rd(3'd1, 32'h07, "rsv_dir");
    rd(3'd2, 32'h18, "rsv_mask");
    rd(3'd3, 32'h08, "rsv_cap");
    rd(3'd4, 32'h0, "rd_outset");
    rd(3'd5, 32'h0, "rd_outclr");
    rd(3'd6, 32'h0, "rd_addr6");
    rd(3'd7, 32'h0, "rd_addr7");
    in_port = 8'hFF;
    ticks(3);
    reset = 1;
    wr(3'd0, 32'h00);
    exp(2'd1, 32'hFF, "rst_beats_write");
    exp(2'd2, 32'hFF, "rst_oe_again");
    exp(2'd3, 32'h0, "rst_irq_again");
    sample();
    reset = 0;
    wr(3'd1, 32'h00);
    wr(3'd2, 32'hFF);
    ticks(4);
    rd(3'd3, 32'h0, "prime_no_cap");
    exp(2'd3, 32'h0, "prime_no_irq");
    rd(3'd0, 32'hFF, "rd_sync_in");
    in_port = 8'hFB;
    ticks(3);
    rd(3'd3, 32'h0, "fall_bit2");
    in_port = 8'hFF;
    ticks(3);
    rd(3'd3, 32'h04, "rise_bit2");
    exp(2'd3, 32'h1, "irq_bit2");
    sample();
    if (total < 12) begin
      bad++;
      $display("FAIL too few checks: total=%0d", total);
    end
    if (bad == 0) $display("PASS");
    else $display("FAIL bad=%0d", bad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
